ram_fifo_ctrl: RTL and testbench
================================

Name: ram_fifo_ctrl

Overview:
- Single-clock FIFO controller that acts as the initiator for the team's 8-bit dual-port RAM macro.
- Both RAM clocks are tied to clk. The RAM has one shared address, a write enable, a read enable and a 1-cycle registered read.
- The block owns the write/read pointers and arbitrates the shared address between pushes and pops.
- It streams bytes out through a 2-entry output skid with valid/ready handshakes on both sides.

Parameters:
- DATA_W, 8, data width of the stream and RAM word.
- ADDR_W, 4, RAM address width; DEPTH = 2**ADDR_W = 16 words.

Ports:
- clk  in  1  system clock; drives the controller and both RAM clock inputs.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  DATA_W  push data.
- in_valid  in  1  push request.
- in_ready  out  1  push accepted this cycle when in_valid & in_ready.
- out_data  out  DATA_W  head of the skid buffer.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer pops when out_valid & out_ready.
- ram_addr  out  ADDR_W  shared RAM address.
- ram_wdata  out  DATA_W  RAM write data (= in_data).
- ram_we  out  1  RAM write enable.
- ram_re  out  1  RAM read enable.
- ram_rdata  in  DATA_W  RAM registered read data; valid the cycle after ram_re.
- level  out  ADDR_W+2  words held = mem_cnt + rd_inflight + skid_cnt (0..DEPTH+2).
- full  out  1  mem_cnt == DEPTH.
- empty  out  1  level == 0.

Behaviour:
- State registers:
  - wr_ptr, rd_ptr (ADDR_W bits, wrap DEPTH-1 -> 0).
  - mem_cnt (0..DEPTH).
  - rd_inflight (1 bit).
  - skid_cnt (0..2), 2-entry skid.
  - last_grant (0 = write, 1 = read).
- Reset (async, rst_n low): all registers 0. Outputs: in_ready=0, out_valid=0, out_data=0, ram_we=0, ram_re=0, ram_addr=0, level=0, full=0, empty=1. RAM contents are treated as garbage afterwards.
- Reset asserted mid-operation: in-flight read data is discarded and the skid is emptied.
- Pop: pop = out_valid & out_ready (combinational).
- Read request: rd_want = mem_cnt>0 & (skid_cnt + rd_inflight - pop) < 2.
- Write request: wr_want = in_valid & mem_cnt<DEPTH.
- Arbitration, one RAM op per cycle:
  - Only one of rd_want/wr_want set: grant it.
  - Both set: grant the side opposite last_grant.
  - last_grant updates only on contention.
- Write grant:
  - ram_we=1, ram_addr=wr_ptr, ram_wdata=in_data.
  - in_ready = grant_w (combinational; may depend on in_valid and out_ready).
  - wr_ptr++, mem_cnt++.
- Read grant:
  - ram_re=1, ram_addr=rd_ptr.
  - rd_ptr++, mem_cnt--, rd_inflight=1 next cycle.
- No grant: ram_we=ram_re=0, ram_addr holds its last value.
- Read landing: in the cycle after ram_re, ram_rdata is written into the skid tail and rd_inflight clears, unless another read is granted that cycle.
- Skid behaviour:
  - Pop and landing in the same cycle: skid_cnt unchanged.
  - out_data is always skid[head].
- Read-after-write: a word written in cycle t is readable at cycle t+1.
- Latency: push into an empty FIFO with out_ready=1 gives out_valid in cycle t+3 (write t, read t+1, land t+2, visible t+3).
- Throughput:
  - Sustained read-only or write-only streaming: 1 word/clk.
  - Concurrent push and pop under contention: each side alternately gets 1 word per 2 clk.
- Boundaries:
  - full: in_ready=0. A same-cycle read grant frees space from the next cycle only.
  - mem_cnt=0: no read issued, even if in_valid is high that cycle.
  - Skid full with out_ready=0: no reads issued; the RAM keeps filling.
- Invariants:
  - ram_we and ram_re are never both 1.
  - level never exceeds DEPTH+2.

Test Plan:
- Reset: drive rst_n low asynchronously mid-stream -> all outputs take reset values immediately; after release, empty=1, level=0, and the next push reads back its own value.
- Single word: push 0xA5 at t with out_ready=1 -> ram_we at t, ram_re at t+1, out_valid=1 and out_data=0xA5 at t+3; level goes 1,1,1,0.
- Fill to full: out_ready=0, push 0x00..0x11 -> the first two words land in the skid, and after 18 accepts full=1, in_ready=0, level=18. Then out_ready=1 -> data 0x00..0x11 emerges in order and pointers wrap 15->0.
- Contention: continuous in_valid and out_ready with mem_cnt>0 -> ram_we/ram_re alternate every cycle, never both high, and data order is preserved.
- Backpressure: toggle out_ready every 2 cycles during a 40-word stream -> no loss or duplication, out_data stable while out_valid & !out_ready, skid_cnt never exceeds 2.
- Wrap: 100 random pushes/pops with random valid/ready -> the scoreboard matches and the level equation holds every cycle.

Source files
------------

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving a single-address dual-port RAM with a 1-cycle registered read.
// Owns the pointers, arbitrates the shared address and streams data out via a 2-entry skid.
module ram_fifo_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [ADDR_W+1:0] level,
  output logic              full,
  output logic              empty
);

  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic {GRANT_W = 1'b0, GRANT_R = 1'b1} grant_e;

  logic [ADDR_W-1:0] wr_ptr, rd_ptr, addr_q;
  logic [ADDR_W:0]   mem_cnt;
  logic              rd_inflight;
  logic [1:0]        skid_cnt;
  logic              skid_head;
  logic [DATA_W-1:0] skid_mem [2];
  grant_e            last_grant;

  logic       pop, rd_want, wr_want, grant_r, grant_w;
  logic [2:0] occ;

  always_comb begin
    pop     = (skid_cnt != 2'd0) && out_ready;
    occ     = {1'b0, skid_cnt} + {2'b00, rd_inflight} - {2'b00, pop};
    rd_want = (mem_cnt != '0) && (occ < 3'd2);
    wr_want = in_valid && (mem_cnt != FULL_CNT);
    // Reads win ties when the last contended grant went to the write side.
    // Grants are masked by rst_n so handshakes and RAM strobes are idle during reset.
    grant_r = rst_n && rd_want && (!wr_want || (last_grant == GRANT_W));
    grant_w = rst_n && wr_want && !grant_r;
  end

  always_comb begin
    ram_addr  = addr_q;
    if (grant_w)      ram_addr = wr_ptr;
    else if (grant_r) ram_addr = rd_ptr;
    ram_we    = grant_w;
    ram_re    = grant_r;
    ram_wdata = in_data;
    in_ready  = grant_w;
    out_valid = (skid_cnt != 2'd0);
    out_data  = skid_mem[skid_head];
    level     = (ADDR_W+2)'(mem_cnt) + (ADDR_W+2)'(rd_inflight) + (ADDR_W+2)'(skid_cnt);
    full      = (mem_cnt == FULL_CNT);
    empty     = (level == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      addr_q      <= '0;
      mem_cnt     <= '0;
      rd_inflight <= 1'b0;
      skid_cnt    <= '0;
      skid_head   <= 1'b0;
      skid_mem    <= '{default: '0};
      last_grant  <= GRANT_W;
    end else begin
      if (grant_w) wr_ptr <= wr_ptr + 1'b1;
      if (grant_r) rd_ptr <= rd_ptr + 1'b1;
      if (grant_w && !grant_r)      mem_cnt <= mem_cnt + 1'b1;
      else if (grant_r && !grant_w) mem_cnt <= mem_cnt - 1'b1;
      if (grant_w || grant_r) addr_q <= ram_addr;
      if (wr_want && rd_want) last_grant <= grant_r ? GRANT_R : GRANT_W;
      rd_inflight <= grant_r;
      // Tail slot is head+cnt mod 2; at cnt==2 a landing always coincides with a pop.
      if (rd_inflight) skid_mem[skid_head ^ skid_cnt[0]] <= ram_rdata;
      if (pop) skid_head <= ~skid_head;
      skid_cnt <= skid_cnt + {1'b0, rd_inflight} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: behavioural RAM, queue-based scoreboard monitor,
// directed latency/fill/contention/backpressure/reset phases plus random traffic.
module tb_ram_fifo_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;
  logic          ram_re;
  logic [DW-1:0] ram_rdata;
  logic [AW+1:0] level;
  logic          full;
  logic          empty;

  always #5 clk = ~clk;

  ram_fifo_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re),
    .ram_rdata(ram_rdata), .level(level), .full(full), .empty(empty)
  );

  // Behavioural RAM macro: synchronous write, registered read.
  logic [DW-1:0] mem [1 << AW];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_addr];
  end

  int n_cmp = 0;
  int n_err = 0;
  int n_pops = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Scoreboard monitor: every accepted push is the expected future pop.
  logic [DW-1:0] exp_q[$];
  int            model_lvl = 0;
  bit            hold_v = 0;
  logic [DW-1:0] hold_d;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      model_lvl = 0;
      hold_v = 0;
    end else begin
      chk("level", int'(level), model_lvl);
      chk("empty", int'(empty), int'(model_lvl == 0));
      chk("we_re_excl", int'(ram_we & ram_re), 0);
      if (full) chk("full_blocks_push", int'(in_ready), 0);
      if (hold_v) begin
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_data", int'(out_data), int'(hold_d));
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(in_data);
        model_lvl++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL pop_unexpected: got data 0x%0h expected no pop at %0t", out_data, $time);
        end else begin
          chk("data", int'(out_data), int'(exp_q.pop_front()));
        end
        model_lvl--;
        n_pops++;
      end
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_data"}, int'(out_data), 0);
    chk({tag, "_ram_we"}, int'(ram_we), 0);
    chk({tag, "_ram_re"}, int'(ram_re), 0);
    chk({tag, "_ram_addr"}, int'(ram_addr), 0);
    chk({tag, "_level"}, int'(level), 0);
    chk({tag, "_full"}, int'(full), 0);
    chk({tag, "_empty"}, int'(empty), 1);
  endtask

  task automatic drain(input string tag);
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      if (level == '0) break;
    end
    chk({tag, "_drained"}, int'(level), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int sent;
    int pops_before;
    logic prev_we;

    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    #1;
    check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Single word latency: write t, read t+1, land t+2, visible t+3.
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
    @(negedge clk);
    chk("sw_we_t0", int'(ram_we), 1);
    chk("sw_in_ready_t0", int'(in_ready), 1);
    chk("sw_addr_t0", int'(ram_addr), 0);
    chk("sw_wdata_t0", int'(ram_wdata), 8'hA5);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("sw_re_t1", int'(ram_re), 1);
    chk("sw_we_t1", int'(ram_we), 0);
    chk("sw_level_t1", int'(level), 1);
    chk("sw_valid_t1", int'(out_valid), 0);
    @(negedge clk);
    chk("sw_valid_t2", int'(out_valid), 0);
    chk("sw_level_t2", int'(level), 1);
    @(negedge clk);
    chk("sw_valid_t3", int'(out_valid), 1);
    chk("sw_data_t3", int'(out_data), 8'hA5);
    chk("sw_level_t3", int'(level), 1);
    @(negedge clk);
    chk("sw_level_t4", int'(level), 0);

    // Fill to full with the consumer stalled; pointers wrap past 15.
    k = 0;
    for (int c = 0; c < 200 && k < 18; c++) begin
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_data = DW'(k);
      @(negedge clk);
      if (in_ready) k++;
    end
    chk("fill_accepts", k, 18);
    @(posedge clk); #1;
    in_data = 8'hEE;
    @(negedge clk);
    chk("fill_full", int'(full), 1);
    chk("fill_in_ready", int'(in_ready), 0);
    chk("fill_level", int'(level), 18);
    chk("fill_head", int'(out_data), 0);
    drain("fill");

    // Contention: continuous push and pop alternate the RAM port.
    @(posedge clk); #1;
    in_valid = 1'b1; out_ready = 1'b1; in_data = DW'($urandom);
    prev_we = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      in_data = DW'($urandom);
      @(negedge clk);
      if (c >= 4) begin
        chk("cont_busy", int'(ram_we | ram_re), 1);
        chk("cont_alternate", int'(ram_we), int'(!prev_we));
      end
      prev_we = ram_we;
    end
    drain("cont");

    // Backpressure: out_ready toggles every 2 cycles over a 40-word stream.
    sent = 0;
    for (int c = 0; c < 400 && sent < 40; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data = DW'($urandom);
      out_ready = ((c / 2) % 2) == 0;
      @(negedge clk);
      if (in_valid && in_ready) sent++;
    end
    chk("bp_sent", sent, 40);
    drain("bp");

    // Random valid/ready traffic.
    for (int c = 0; c < 150; c++) begin
      @(posedge clk); #1;
      in_valid = 1'($urandom_range(0, 1));
      in_data = DW'($urandom);
      out_ready = 1'($urandom_range(0, 1));
    end
    drain("rand");

    // Asynchronous reset in the middle of a stream.
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data = DW'($urandom);
      out_ready = 1'b0;
    end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid");
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    pops_before = n_pops;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 8'h5C; out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_accept", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain("post_rst");
    chk("post_rst_pops", n_pops - pops_before, 1);

    chk("sb_leftover", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
